// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory path: responder FSM states and width constants.
package mips_mem_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = WORD_W / 8;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous word RAM with per-byte write enables and one registered read port; no reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding request, programmable wait states,
// range/alignment error check, word RAM behind it.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                r_state, w_next_state;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                  r_req_ready;
  logic                  r_we;
  logic [WORD_W-1:0]     r_addr;
  logic [WORD_W-1:0]     r_wdata;
  logic [BE_W-1:0]       r_be;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_rd_ok;

  logic                  w_accept;
  logic                  w_access;
  logic                  w_done;
  logic                  w_err;
  logic                  w_mem_ok;
  logic [BE_W-1:0]       w_ram_we;
  logic                  w_ram_re;
  logic [WORD_W-1:0]     w_ram_rdata;

  assign w_accept = req_valid & r_req_ready;
  // First RESP cycle performs the RAM access; rsp_valid rises on that same edge.
  assign w_access = (r_state == RESP) & ~r_rsp_valid;
  assign w_done   = r_rsp_valid & rsp_ready;
  assign w_err    = (r_addr[1:0] != 2'b00) | (r_addr[WORD_W-1:ADDR_W+2] != '0);
  assign w_mem_ok = w_access & ~w_err;
  assign w_ram_we = (w_mem_ok & r_we) ? r_be : '0;
  assign w_ram_re = w_mem_ok & ~r_we;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next_state = RESP;
        else             w_cnt_next   = r_cnt - WAIT_CNT_W'(1);
      end
      RESP: begin
        if (w_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next_state == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else if (w_access) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rd_ok     <= ~r_we & ~w_err;
    end else if (w_done) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (r_addr[ADDR_W+1:2]),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  // RAM output register has no reset; it is only exposed for a successful read.
  assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 with two wait states, instance 1 with none.
module tb_dmem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the handshake edge.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                     output logic [31:0] rdata, output logic err);
    int n = 0;
    while (!req_ready[d] && n < 20) begin tick(); n++; end
    chk("req_ready_before_txn", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    tick();
    req_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 50) begin tick(); n++; end
    chk("latency", 32'(n), 32'(exp_lat));
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid[d]), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready[d]), 32'd1);
  endtask

  vec_t vecs[18];

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hA, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h11AD_33AA, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0011, 32'h0000_0000, 4'hF, 32'h0, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h11AD_33AA, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0};
    vecs[17] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h0, 1'b1};

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = '0;
    rst_n = 1'b0;

    repeat (3) tick();
    chk("rst_req_ready0", 32'(req_ready[0]), 32'd0);
    chk("rst_req_ready1", 32'(req_ready[1]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("req_ready_after_release", 32'(req_ready[0]), 32'd1);

    for (int i = 0; i < 18; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 3, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Zero wait states: preload, then back-to-back reads with rsp_ready held high.
    txn(1, 1'b1, 32'h0, 32'h0101_0101, 4'hF, 1, rd, er);
    txn(1, 1'b1, 32'h4, 32'h0202_0202, 4'hF, 1, rd, er);
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
    tick();
    req_addr[1] = 32'h4;
    chk("b2b_no_early_valid", 32'(rsp_valid[1]), 32'd0);
    tick();
    chk("b2b_valid0", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_rdata0", rsp_rdata[1], 32'h0101_0101);
    chk("b2b_ready_low", 32'(req_ready[1]), 32'd0);
    tick();
    chk("b2b_hs0", 32'(rsp_valid[1]), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    tick();
    chk("b2b_valid1", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_rdata1", rsp_rdata[1], 32'h0202_0202);
    tick();
    chk("b2b_hs1", 32'(rsp_valid[1]), 32'd0);
    rsp_ready[1] = 1'b0;

    // Backpressure: response must hold for 5 cycles with rsp_ready low.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin tick(); n++; end
    chk("bp_latency", 32'(n), 32'd3);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_valid_c%0d", c), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), rsp_rdata[0], 32'h11AD_33AA);
      chk($sformatf("bp_req_ready_c%0d", c), 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    chk("bp_valid_dropped", 32'(rsp_valid[0]), 32'd0);
    chk("bp_req_ready_back", 32'(req_ready[0]), 32'd1);

    // Reset while a write sits in WAIT: the write must be lost.
    txn(0, 1'b1, 32'h20, 32'h1111_1111, 4'hF, 3, rd, er);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h1234_5678; req_be[0] = 4'hF;
    tick();
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midwait_req_ready", 32'(req_ready[0]), 32'd0);
    chk("midwait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midwait_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midwait_rsp_err", 32'(rsp_err[0]), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 3, rd, er);
    chk("midwait_old_data", rd, 32'h1111_1111);

    // Reset once the write reached RESP: the write stays committed.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'hF;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin tick(); n++; end
    chk("midresp_latency", 32'(n), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midresp_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 3, rd, er);
    chk("midresp_new_data", rd, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
